// File: rtl/fifo_if_pkg.sv
// Shared types for the multi-channel FIFO write interface: per-channel state
// encoding and the width helper for the round-robin pointer.
package fifo_if_pkg;

   typedef enum logic [1:0] {
      CH_IDLE    = 2'd0,
      CH_ARMED   = 2'd1,
      CH_QUEUED  = 2'd2,
      CH_RELEASE = 2'd3
   } ch_state_e;

   // A single channel still needs a 1-bit pointer/index so the vectors stay legal.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr_i,
// wrapping explicitly at NCH-1.
module rr_arbiter
   import fifo_if_pkg::*;
#(
   parameter int NCH = 4,
   parameter int PW  = 2
) (
   input  logic [NCH-1:0] req_i,
   input  logic [PW-1:0]  ptr_i,
   output logic [NCH-1:0] gnt_o,
   output logic [PW-1:0]  idx_o,
   output logic           any_o
);

   int c;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      c     = 0;
      for (int k = 1; k <= NCH; k++) begin
         c = int'(ptr_i) + k;
         if (c >= NCH) begin
            c = c - NCH;
         end
         if (!any_o && ((req_i >> c) & NCH'(1)) != '0) begin
            any_o = 1'b1;
            gnt_o = NCH'(1) << c;
            idx_o = PW'(c);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_if_mc.sv
// Multi-channel write front end: NCH level-request producers are arbitrated
// round-robin into one holding register that drives the FIFO write port.
module fifo_wr_if_mc
   import fifo_if_pkg::*;
#(
   parameter int DW     = 4,
   parameter int NCH    = 4,
   parameter int STREAM = 0
) (
   input  logic              clk_1,
   input  logic              reset,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH*DW-1:0] ch_data,
   input  logic              wfull,
   output logic              winc,
   output logic [DW-1:0]     wdata,
   output logic [NCH-1:0]    ch_ack,
   output logic              busy
);

   localparam int PW = ptr_width(NCH);

   logic              hold_vld_q, hold_vld_d;
   logic [DW-1:0]     hold_data_q, hold_data_d;
   logic [PW-1:0]     hold_ch_q, hold_ch_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [NCH-1:0]    ack_q, ack_d;

   logic [NCH-1:0]    elig;
   logic [NCH-1:0]    gnt;
   logic [PW-1:0]     sel_idx;
   logic              sel_any;
   logic [DW-1:0]     sel_data;
   logic              drain;
   logic              load;

   rr_arbiter #(
      .NCH (NCH),
      .PW  (PW)
   ) u_arb (
      .req_i (elig),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (sel_idx),
      .any_o (sel_any)
   );

   // The FIFO consumes hold_data at the same edge that frees the slot, so a
   // new word may be loaded on that edge without a bubble.
   assign drain    = hold_vld_q & ~wfull;
   assign load     = (~hold_vld_q | drain) & sel_any;
   assign sel_data = DW'(ch_data >> (int'(sel_idx) * DW));

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         ch_state_e st_q, st_d;
         logic      mine;

         assign mine = (hold_ch_q == PW'(gi));

         always_comb begin
            st_d = st_q;
            case (st_q)
               CH_IDLE:    st_d = CH_ARMED;
               CH_ARMED:   if (load && gnt[gi]) st_d = CH_QUEUED;
               CH_QUEUED:  if (drain && mine) st_d = (STREAM != 0) ? CH_ARMED : CH_RELEASE;
               CH_RELEASE: if (!ch_req[gi]) st_d = CH_ARMED;
               default:    st_d = CH_IDLE;
            endcase
         end

         always_ff @(posedge clk_1 or negedge reset) begin
            if (!reset) begin
               st_q <= CH_IDLE;
            end else begin
               st_q <= st_d;
            end
         end

         assign elig[gi]  = (st_q == CH_ARMED) & ch_req[gi];
         assign ack_d[gi] = drain & mine;
      end
   endgenerate

   always_comb begin
      hold_vld_d  = hold_vld_q;
      hold_data_d = hold_data_q;
      hold_ch_d   = hold_ch_q;
      ptr_d       = ptr_q;
      if (load) begin
         hold_vld_d  = 1'b1;
         hold_data_d = sel_data;
         hold_ch_d   = sel_idx;
         ptr_d       = sel_idx;
      end else if (drain) begin
         hold_vld_d  = 1'b0;
      end
   end

   // Pointer starts at the last channel so channel 0 wins the first arbitration.
   always_ff @(posedge clk_1 or negedge reset) begin
      if (!reset) begin
         hold_vld_q  <= 1'b0;
         hold_data_q <= '0;
         hold_ch_q   <= '0;
         ptr_q       <= PW'(NCH - 1);
         ack_q       <= '0;
      end else begin
         hold_vld_q  <= hold_vld_d;
         hold_data_q <= hold_data_d;
         hold_ch_q   <= hold_ch_d;
         ptr_q       <= ptr_d;
         ack_q       <= ack_d;
      end
   end

   assign winc   = hold_vld_q;
   assign busy   = hold_vld_q;
   assign wdata  = hold_data_q;
   assign ch_ack = ack_q;

endmodule

// File: tb/tb_fifo_wr_if_mc.sv
// Bench for fifo_wr_if_mc: directed vector tables, hand-written corner
// sequences and randomized traffic against a rule-level reference model.
module tb_fifo_wr_if_mc;

   logic clk;
   logic reset;

   logic [3:0]  req_a, ack_a, wdata_a;
   logic [15:0] data_a;
   logic        full_a, winc_a, busy_a;

   logic [3:0]  req_s, ack_s, wdata_s;
   logic [15:0] data_s;
   logic        full_s, winc_s, busy_s;

   logic [0:0]  req_1, ack_1;
   logic [7:0]  data_1, wdata_1;
   logic        full_1, winc_1, busy_1;

   int n_pass;
   int n_total;

   fifo_wr_if_mc #(.DW(4), .NCH(4), .STREAM(0)) u_dut (
      .clk_1(clk), .reset(reset), .ch_req(req_a), .ch_data(data_a), .wfull(full_a),
      .winc(winc_a), .wdata(wdata_a), .ch_ack(ack_a), .busy(busy_a));

   fifo_wr_if_mc #(.DW(4), .NCH(4), .STREAM(1)) u_str (
      .clk_1(clk), .reset(reset), .ch_req(req_s), .ch_data(data_s), .wfull(full_s),
      .winc(winc_s), .wdata(wdata_s), .ch_ack(ack_s), .busy(busy_s));

   fifo_wr_if_mc #(.DW(8), .NCH(1), .STREAM(0)) u_one (
      .clk_1(clk), .reset(reset), .ch_req(req_1), .ch_data(data_1), .wfull(full_1),
      .winc(winc_1), .wdata(wdata_1), .ch_ack(ack_1), .busy(busy_1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] data;
      logic        full;
      logic        exp_winc;
      logic [7:0]  exp_wdata;
      logic [3:0]  exp_ack;
      bit          pre_rst;
   } vec_t;

   vec_t tab_a[$];
   vec_t tab_1[$];

   function automatic vec_t v(input logic [3:0] rq, input logic [15:0] d, input logic f,
                              input logic ew, input logic [7:0] ed, input logic [3:0] ea,
                              input bit pr);
      vec_t r;
      r.req = rq; r.data = d; r.full = f; r.exp_winc = ew;
      r.exp_wdata = ed; r.exp_ack = ea; r.pre_rst = pr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference model: per-channel "word in flight" and "must see req low" flags,
   // one pending word, and the last granted channel.
   bit         m_vld[2];
   logic [3:0] m_data[2];
   int         m_ch[2];
   int         m_ptr[2];
   bit         m_live[2];
   logic [3:0] m_ack[2];
   bit         m_inflight[2][4];
   bit         m_spent[2][4];

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         m_vld[m] = 0; m_data[m] = '0; m_ch[m] = 0; m_ptr[m] = 3;
         m_live[m] = 0; m_ack[m] = '0;
         for (int i = 0; i < 4; i++) begin
            m_inflight[m][i] = 0;
            m_spent[m][i] = 0;
         end
      end
   endfunction

   function automatic void model_step(input int m, input logic [3:0] req, input logic [15:0] din,
                                      input logic full, input bit stream);
      bit wr;
      int pick;
      int c;
      wr = m_vld[m] && !full;
      pick = -1;
      if (m_live[m] && (!m_vld[m] || wr)) begin
         for (int k = 1; k <= 4; k++) begin
            c = (m_ptr[m] + k) % 4;
            if (pick < 0 && req[c] && !m_inflight[m][c] && !m_spent[m][c]) pick = c;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (m_spent[m][i] && !req[i]) m_spent[m][i] = 0;
      end
      m_ack[m] = wr ? 4'(1 << m_ch[m]) : 4'd0;
      if (wr) begin
         m_inflight[m][m_ch[m]] = 0;
         if (!stream) m_spent[m][m_ch[m]] = 1;
      end
      if (pick >= 0) begin
         m_inflight[m][pick] = 1;
         m_vld[m] = 1;
         m_data[m] = din[pick*4 +: 4];
         m_ch[m] = pick;
         m_ptr[m] = pick;
      end else if (wr) begin
         m_vld[m] = 0;
      end
      m_live[m] = 1;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      req_a = '0; data_a = '0; full_a = 1'b0;
      req_s = '0; data_s = '0; full_s = 1'b0;
      req_1 = '0; data_1 = '0; full_1 = 1'b0;
      model_reset();
      #1;
      chk("rst winc_a", winc_a, 0); chk("rst busy_a", busy_a, 0);
      chk("rst wdata_a", wdata_a, 0); chk("rst ack_a", ack_a, 0);
      chk("rst winc_s", winc_s, 0); chk("rst ack_s", ack_s, 0);
      chk("rst winc_1", winc_1, 0); chk("rst wdata_1", wdata_1, 0);
      chk("rst ack_1", ack_1, 0); chk("rst busy_1", busy_1, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic idle_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 99) < 30) req_a[i] = ~req_a[i];
         if ($urandom_range(0, 99) < 30) req_s[i] = ~req_s[i];
      end
      data_a = 16'($urandom);
      data_s = 16'($urandom);
      full_a = ($urandom_range(0, 99) < 25);
      full_s = ($urandom_range(0, 99) < 25);
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      reset = 1'b1;

      // single channel, all four channels in order, then wfull stall on channel 2
      tab_a.push_back(v(4'b0001, 16'h000A, 0, 1, 8'hA, 4'b0000, 1));
      tab_a.push_back(v(4'b0001, 16'h000A, 0, 0, 8'h0, 4'b0001, 0));
      for (int i = 0; i < 3; i++) tab_a.push_back(v(4'b0001, 16'h000A, 0, 0, 8'h0, 4'b0000, 0));
      tab_a.push_back(v(4'b0000, 16'h000A, 0, 0, 8'h0, 4'b0000, 0));
      tab_a.push_back(v(4'b0001, 16'h0003, 0, 1, 8'h3, 4'b0000, 0));
      tab_a.push_back(v(4'b0001, 16'h0003, 0, 0, 8'h0, 4'b0001, 0));
      tab_a.push_back(v(4'b0000, 16'h0003, 0, 0, 8'h0, 4'b0000, 0));
      tab_a.push_back(v(4'b1111, 16'h4321, 0, 1, 8'h1, 4'b0000, 1));
      tab_a.push_back(v(4'b1111, 16'h4321, 0, 1, 8'h2, 4'b0001, 0));
      tab_a.push_back(v(4'b1111, 16'h4321, 0, 1, 8'h3, 4'b0010, 0));
      tab_a.push_back(v(4'b1111, 16'h4321, 0, 1, 8'h4, 4'b0100, 0));
      tab_a.push_back(v(4'b0000, 16'h4321, 0, 0, 8'h0, 4'b1000, 0));
      tab_a.push_back(v(4'b0000, 16'h4321, 0, 0, 8'h0, 4'b0000, 0));
      tab_a.push_back(v(4'b0100, 16'h4721, 1, 1, 8'h7, 4'b0000, 0));
      for (int i = 0; i < 6; i++) tab_a.push_back(v(4'b1111, 16'h4721, 1, 1, 8'h7, 4'b0000, 0));
      tab_a.push_back(v(4'b1111, 16'h4721, 0, 1, 8'h4, 4'b0100, 0));
      tab_a.push_back(v(4'b1111, 16'h4721, 0, 1, 8'h1, 4'b1000, 0));
      tab_a.push_back(v(4'b0000, 16'h4721, 0, 0, 8'h0, 4'b0001, 0));
      tab_a.push_back(v(4'b0000, 16'h4721, 0, 0, 8'h0, 4'b0000, 0));

      tab_1.push_back(v(4'b0001, 16'h005A, 0, 1, 8'h5A, 4'b0000, 1));
      tab_1.push_back(v(4'b0001, 16'h005A, 0, 0, 8'h00, 4'b0001, 0));
      tab_1.push_back(v(4'b0000, 16'h005A, 0, 0, 8'h00, 4'b0000, 0));
      tab_1.push_back(v(4'b0001, 16'h00C3, 0, 1, 8'hC3, 4'b0000, 0));
      tab_1.push_back(v(4'b0001, 16'h00C3, 0, 0, 8'h00, 4'b0001, 0));
      tab_1.push_back(v(4'b0000, 16'h00C3, 0, 0, 8'h00, 4'b0000, 0));

      #2;
      foreach (tab_a[i]) begin
         if (tab_a[i].pre_rst) begin
            do_reset();
            idle_edge();
         end
         req_a = tab_a[i].req; data_a = tab_a[i].data; full_a = tab_a[i].full;
         @(posedge clk);
         #1;
         chk($sformatf("a%0d winc", i), winc_a, tab_a[i].exp_winc);
         chk($sformatf("a%0d busy", i), busy_a, tab_a[i].exp_winc);
         if (tab_a[i].exp_winc) chk($sformatf("a%0d wdata", i), wdata_a, tab_a[i].exp_wdata[3:0]);
         chk($sformatf("a%0d ack", i), ack_a, tab_a[i].exp_ack);
         $display("vec a%0d req=%b full=%b winc=%b wdata=%h ack=%b", i, req_a, full_a, winc_a, wdata_a, ack_a);
      end

      foreach (tab_1[i]) begin
         if (tab_1[i].pre_rst) begin
            do_reset();
            idle_edge();
         end
         req_1 = tab_1[i].req[0:0]; data_1 = tab_1[i].data[7:0]; full_1 = tab_1[i].full;
         @(posedge clk);
         #1;
         chk($sformatf("n1_%0d winc", i), winc_1, tab_1[i].exp_winc);
         if (tab_1[i].exp_winc) chk($sformatf("n1_%0d wdata", i), wdata_1, tab_1[i].exp_wdata);
         chk($sformatf("n1_%0d ack", i), ack_1, tab_1[i].exp_ack[0:0]);
         $display("vec n1_%0d req=%b winc=%b wdata=%h ack=%b", i, req_1, winc_1, wdata_1, ack_1);
      end

      // streaming: channel 1 alone writes every second cycle, then 0/1 alternate
      do_reset();
      idle_edge();
      req_s = 4'b0010;
      for (int k = 0; k < 8; k++) begin
         data_s = {8'h00, 4'(k + 1), 4'h0};
         @(posedge clk);
         #1;
         chk($sformatf("s1_%0d winc", k), winc_s, (k % 2 == 0));
         if (k % 2 == 0) chk($sformatf("s1_%0d wdata", k), wdata_s, 4'(k + 1));
         chk($sformatf("s1_%0d ack", k), ack_s, (k % 2 == 1) ? 4'b0010 : 4'b0000);
         $display("str k=%0d winc=%b wdata=%h ack=%b", k, winc_s, wdata_s, ack_s);
      end
      req_s = 4'b0011;
      data_s = 16'h00DC;
      for (int j = 0; j < 8; j++) begin
         @(posedge clk);
         #1;
         chk($sformatf("s2_%0d winc", j), winc_s, 1);
         chk($sformatf("s2_%0d wdata", j), wdata_s, (j % 2 == 0) ? 4'hC : 4'hD);
         chk($sformatf("s2_%0d ack", j), ack_s,
             (j == 0) ? 4'b0000 : ((j % 2 == 1) ? 4'b0001 : 4'b0010));
         $display("str j=%0d winc=%b wdata=%h ack=%b", j, winc_s, wdata_s, ack_s);
      end

      // reset while a word is held: it must vanish, then one idle cycle
      do_reset();
      idle_edge();
      req_a = 4'b0001; data_a = 16'h0005;
      @(posedge clk);
      #1;
      chk("mr held winc", winc_a, 1);
      chk("mr held wdata", wdata_a, 4'h5);
      #3;
      reset = 1'b0;
      #1;
      chk("mr async winc", winc_a, 0);
      chk("mr async busy", busy_a, 0);
      chk("mr async wdata", wdata_a, 0);
      @(posedge clk);
      #1;
      chk("mr in-reset ack", ack_a, 0);
      data_a = 16'h0006;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mr idle winc", winc_a, 0);
      chk("mr idle ack", ack_a, 0);
      @(posedge clk);
      #1;
      chk("mr load winc", winc_a, 1);
      chk("mr load wdata", wdata_a, 4'h6);
      @(posedge clk);
      #1;
      chk("mr write ack", ack_a, 4'b0001);
      $display("reset-mid-op sequence done winc=%b ack=%b", winc_a, ack_a);

      // randomized traffic on both 4-channel builds against the model
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         rand_inputs();
         @(posedge clk);
         model_step(0, req_a, data_a, full_a, 0);
         model_step(1, req_s, data_s, full_s, 1);
         #1;
         chk("rnd a winc", winc_a, m_vld[0]);
         chk("rnd a busy", busy_a, m_vld[0]);
         chk("rnd a ack", ack_a, m_ack[0]);
         if (m_vld[0]) chk("rnd a wdata", wdata_a, m_data[0]);
         chk("rnd s winc", winc_s, m_vld[1]);
         chk("rnd s ack", ack_s, m_ack[1]);
         if (m_vld[1]) chk("rnd s wdata", wdata_s, m_data[1]);
         if (m_ack[0] != 0) $display("rnd cyc=%0d a ack=%b", cyc, ack_a);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
